regfile_wb_driver: RTL and testbench

// - Write-side driver for the register file: turns ALU results and memory loads into its

---
 rtl/regfile_wb_driver_pkg.sv | 24 ++
 rtl/regfile_wb_driver_if.sv | 38 +++
 rtl/regfile_wb_driver_skid.sv | 34 +++
 rtl/regfile_wb_driver.sv | 147 ++++++++++++++
 tb/tb_regfile_wb_driver.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_driver_pkg.sv
// Shared widths, load FSM encoding and the write-entry type for the register-file write driver.
package regfile_wb_driver_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 32;
    localparam int REGW = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2
    } ld_state_t;

    typedef struct packed {
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    // x0 is hard-wired: entries targeting it are consumed without a write strobe.
    function automatic logic writes_reg(input logic [REGW-1:0] r);
        return r != '0;
    endfunction

endpackage

// File: rtl/regfile_wb_driver_if.sv
// Bundle of ALU, load, memory and register-file write-port signals around the write driver.
interface regfile_wb_driver_if;
    import regfile_wb_driver_pkg::*;

    logic            alu_valid;
    logic            alu_ready;
    logic [REGW-1:0] alu_rd;
    logic [XLEN-1:0] alu_result;
    logic            ld_valid;
    logic            ld_ready;
    logic [REGW-1:0] ld_rd;
    logic [AW-1:0]   ld_addr;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic            wr_en;
    logic            load;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] memory;
    logic            ld_busy;
    logic [REGW-1:0] ld_busy_rd;
    logic            ld_err;

    modport master (
        input  alu_valid, alu_rd, alu_result, ld_valid, ld_rd, ld_addr, mem_ack, mem_rdata,
        output alu_ready, ld_ready, mem_req, mem_addr, wr_en, load, rd, result, memory,
               ld_busy, ld_busy_rd, ld_err
    );

    modport slave (
        output alu_valid, alu_rd, alu_result, ld_valid, ld_rd, ld_addr, mem_ack, mem_rdata,
        input  alu_ready, ld_ready, mem_req, mem_addr, wr_en, load, rd, result, memory,
               ld_busy, ld_busy_rd, ld_err
    );

endinterface

// File: rtl/regfile_wb_driver_skid.sv
// One-entry valid/ready skid buffer holding an ALU write {rd, result} displaced by a load write.
module regfile_wb_driver_skid
    import regfile_wb_driver_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      in_valid,
    output logic      in_ready,
    input  wb_entry_t in_data,
    output logic      out_valid,
    input  logic      out_ready,
    output wb_entry_t out_data
);

    logic      full;
    wb_entry_t entry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (in_valid && in_ready) begin
            full  <= 1'b1;
            entry <= in_data;
        end else if (out_ready && full) begin
            full <= 1'b0;
        end
    end

    assign in_ready  = !full;
    assign out_valid = full;
    assign out_data  = entry;

endmodule

// File: rtl/regfile_wb_driver.sv
// Register-file write-side driver: load memory FSM with timeout, ALU skid buffer and a
// registered write port shared by both paths (load write > skid > new ALU entry).
//
// state    | meaning
// ST_IDLE  | no load in flight, ld_ready=1
// ST_REQ   | mem_req held with latched address, waiting for ack or timeout
// ST_WRITE | captured load data on the write port this cycle
module regfile_wb_driver
    import regfile_wb_driver_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wb_driver_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    ld_state_t       state, state_nxt;
    logic [CW-1:0]   wait_cnt;
    logic [REGW-1:0] ld_rd_q;
    logic [AW-1:0]   ld_addr_q;
    logic            ack_hit, timed_out, alu_fire;
    logic            ld_ready_c, mem_req_c, ld_busy_c;
    logic            skid_in_ready, skid_valid;
    wb_entry_t       alu_entry, skid_entry;
    logic            wr_en_q, load_q, ld_err_q;
    logic [REGW-1:0] rd_q;
    logic [XLEN-1:0] result_q, memory_q;

    assign ack_hit   = (state == ST_REQ) && bus.mem_ack;
    assign timed_out = (state == ST_REQ) && !bus.mem_ack && (wait_cnt == CW'(TIMEOUT - 1));
    assign alu_fire  = bus.alu_valid && skid_in_ready;
    assign alu_entry = {bus.alu_rd, bus.alu_result};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (bus.ld_valid) state_nxt = ST_REQ;
            ST_REQ: begin
                if (bus.mem_ack)    state_nxt = ST_WRITE;
                else if (timed_out) state_nxt = ST_IDLE;
            end
            ST_WRITE: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_ready_c = 1'b0;
        mem_req_c  = 1'b0;
        ld_busy_c  = 1'b0;
        unique case (state)
            ST_IDLE:  ld_ready_c = 1'b1;
            ST_REQ: begin
                mem_req_c = 1'b1;
                ld_busy_c = 1'b1;
            end
            ST_WRITE: ld_busy_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if ((state == ST_REQ) && !bus.mem_ack && !timed_out) begin
            wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_rd_q   <= '0;
            ld_addr_q <= '0;
        end else if (bus.ld_valid && ld_ready_c) begin
            ld_rd_q   <= bus.ld_rd;
            ld_addr_q <= bus.ld_addr;
        end
    end

    // An ALU entry accepted on the ack edge loses the port to the load and parks in the skid.
    regfile_wb_driver_skid u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bus.alu_valid && ack_hit),
        .in_ready  (skid_in_ready),
        .in_data   (alu_entry),
        .out_valid (skid_valid),
        .out_ready (!ack_hit),
        .out_data  (skid_entry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q  <= 1'b0;
            load_q   <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
            memory_q <= '0;
            ld_err_q <= 1'b0;
        end else begin
            ld_err_q <= timed_out;
            if (ack_hit) begin
                wr_en_q  <= writes_reg(ld_rd_q);
                load_q   <= 1'b1;
                rd_q     <= ld_rd_q;
                memory_q <= bus.mem_rdata;
            end else if (skid_valid) begin
                wr_en_q  <= writes_reg(skid_entry.rd);
                load_q   <= 1'b0;
                rd_q     <= skid_entry.rd;
                result_q <= skid_entry.data;
            end else if (alu_fire) begin
                wr_en_q  <= writes_reg(bus.alu_rd);
                load_q   <= 1'b0;
                rd_q     <= bus.alu_rd;
                result_q <= bus.alu_result;
            end else begin
                wr_en_q <= 1'b0;
                load_q  <= 1'b0;
            end
        end
    end

    assign bus.alu_ready  = skid_in_ready;
    assign bus.ld_ready   = ld_ready_c;
    assign bus.mem_req    = mem_req_c;
    assign bus.mem_addr   = ld_addr_q;
    assign bus.ld_busy    = ld_busy_c;
    assign bus.ld_busy_rd = ld_rd_q;
    assign bus.ld_err     = ld_err_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.load       = load_q;
    assign bus.rd         = rd_q;
    assign bus.result     = result_q;
    assign bus.memory     = memory_q;

endmodule

// File: tb/tb_regfile_wb_driver.sv
// Self-checking bench for regfile_wb_driver: ALU vector table, load/timeout/collision/reset
// sequences, and a write-order scoreboard fed at stimulus time.
module tb_regfile_wb_driver;

    localparam int TO = 16;

    typedef struct {
        logic        load;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        exp_wr;
    } alu_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    int   ack_delay = 1000;
    logic [31:0] ack_data = '0;

    regfile_wb_driver_if bus();

    regfile_wb_driver #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory responder: acks in the ack_delay-th cycle (0-based) of a mem_req burst.
    initial begin
        int req_cycles = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                bus.mem_ack   = (req_cycles == ack_delay);
                bus.mem_rdata = (req_cycles == ack_delay) ? ack_data : 32'hdead_0000 + req_cycles;
                req_cycles++;
            end else begin
                req_cycles    = 0;
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = '0;
            end
        end
    end

    // Write monitor: every strobe must match the oldest expected write.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.wr_en === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_write actual rd=%0d load=%0d required no write", bus.rd, bus.load);
                end else begin
                    e = sb.pop_front();
                    if (bus.load !== e.load || bus.rd !== e.rd ||
                        (e.load ? bus.memory : bus.result) !== e.data) begin
                        bad++;
                        $display("FAIL sb_write actual load=%0d rd=%0d data=%0h required load=%0d rd=%0d data=%0h",
                                 bus.load, bus.rd, e.load ? bus.memory : bus.result, e.load, e.rd, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_load(input logic [4:0] rdx, input logic [31:0] addr, input logic [31:0] data,
                           input int delay, input bit exp_err);
        int n;
        logic [31:0] seen_addr;
        @(negedge clk);
        check("ld_ready_idle", bus.ld_ready, 1);
        bus.ld_valid = 1'b1;
        bus.ld_rd    = rdx;
        bus.ld_addr  = addr;
        ack_delay    = delay;
        ack_data     = data;
        if (!exp_err && rdx != 0) sb.push_back('{1'b1, rdx, data});
        @(negedge clk);
        bus.ld_valid = 1'b0;
        check("ld_busy_req", bus.ld_busy, 1);
        check("ld_busy_rd", bus.ld_busy_rd, rdx);
        check("ld_ready_req", bus.ld_ready, 0);
        n = 0;
        seen_addr = addr;
        for (int c = 0; c < 40 && bus.mem_req === 1'b1; c++) begin
            if (bus.mem_addr !== addr) seen_addr = bus.mem_addr;
            n++;
            @(negedge clk);
        end
        check("mem_addr_stable", seen_addr, addr);
        check("mem_req_cycles", n, exp_err ? TO : delay + 1);
        if (!exp_err) begin
            check("ld_wr_en", bus.wr_en, (rdx != 0));
            check("ld_load", bus.load, 1);
            check("ld_rd", bus.rd, rdx);
            check("ld_memory", bus.memory, data);
            check("ld_no_err", bus.ld_err, 0);
            check("ld_busy_write", bus.ld_busy, 1);
            @(negedge clk);
            check("ld_busy_after", bus.ld_busy, 0);
            check("ld_ready_after", bus.ld_ready, 1);
            check("ld_wr_after", bus.wr_en, 0);
        end else begin
            check("to_err_pulse", bus.ld_err, 1);
            check("to_no_write", bus.wr_en, 0);
            check("to_ld_ready", bus.ld_ready, 1);
            check("to_busy_clear", bus.ld_busy, 0);
            @(negedge clk);
            check("to_err_one_cycle", bus.ld_err, 0);
        end
    endtask

    initial begin
        alu_vec_t vec[7];
        vec[0] = '{1'b1, 5'd2,  32'h0000_2267, 1'b1};
        vec[1] = '{1'b0, 5'd9,  32'h1111_1111, 1'b0};
        vec[2] = '{1'b1, 5'd7,  32'hdead_beef, 1'b1};
        vec[3] = '{1'b1, 5'd8,  32'h1234_5678, 1'b1};
        vec[4] = '{1'b1, 5'd0,  32'h0000_ffff, 1'b0};
        vec[5] = '{1'b1, 5'd31, 32'h0000_a5a5, 1'b1};
        vec[6] = '{1'b0, 5'd3,  32'h7777_7777, 1'b0};

        bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_result = '0;
        bus.ld_valid = 0;  bus.ld_rd = '0;  bus.ld_addr = '0;

        repeat (2) @(negedge clk);
        check("rst_alu_ready", bus.alu_ready, 1);
        check("rst_ld_ready", bus.ld_ready, 1);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_ld_busy", bus.ld_busy, 0);
        check("rst_ld_err", bus.ld_err, 0);
        check("rst_rd", bus.rd, 0);
        check("rst_memory", bus.memory, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i > 0) check("alu_tbl_wr", bus.wr_en, vec[i-1].exp_wr);
            check("alu_tbl_ready", bus.alu_ready, 1);
            bus.alu_valid  = vec[i].v;
            bus.alu_rd     = vec[i].rd;
            bus.alu_result = vec[i].res;
            if (vec[i].v && vec[i].rd != 0) sb.push_back('{1'b0, vec[i].rd, vec[i].res});
        end
        @(negedge clk);
        bus.alu_valid = 1'b0;
        check("alu_tbl_wr", bus.wr_en, vec[6].exp_wr);
        check("idle_rd_hold", bus.rd, 31);
        check("idle_result_hold", bus.result, 32'h0000_a5a5);
        check("idle_load", bus.load, 0);

        do_load(5'd1, 32'h40, 32'hbfbf, 3, 1'b0);
        check("alu_memory_hold_pre", bus.memory, 32'hbfbf);

        // Collision: ALU accepted on the ack edge must trail the load write by one cycle.
        @(negedge clk);
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd3; bus.ld_addr = 32'h80;
        ack_delay = 2; ack_data = 32'h3333;
        sb.push_back('{1'b1, 5'd3, 32'h3333});
        @(negedge clk);
        bus.ld_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("col_mem_ack", bus.mem_ack, 1);
        check("col_alu_ready_pre", bus.alu_ready, 1);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_result = 32'h55;
        sb.push_back('{1'b0, 5'd5, 32'h55});
        @(negedge clk);
        check("col_ld_first", bus.load, 1);
        check("col_ld_rd", bus.rd, 3);
        check("col_alu_stall", bus.alu_ready, 0);
        bus.alu_rd = 5'd6; bus.alu_result = 32'h66;
        @(negedge clk);
        check("col_alu_wr", bus.wr_en, 1);
        check("col_alu_rd", bus.rd, 5);
        check("col_alu_res", bus.result, 32'h55);
        check("col_mem_hold", bus.memory, 32'h3333);
        check("col_alu_ready_post", bus.alu_ready, 1);
        sb.push_back('{1'b0, 5'd6, 32'h66});
        @(negedge clk);
        bus.alu_valid = 1'b0;
        check("col_newer_rd", bus.rd, 6);
        @(negedge clk);
        check("col_idle", bus.wr_en, 0);

        do_load(5'd4, 32'h100, 32'h4444, 1000, 1'b1);
        do_load(5'd9, 32'h104, 32'h9999, TO - 1, 1'b0);
        do_load(5'd0, 32'h200, 32'h1234, 1, 1'b0);

        // Reset asserted between edges while the load waits in REQ.
        @(negedge clk);
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd10; bus.ld_addr = 32'h300;
        ack_delay = 1000;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        check("rr_mem_req", bus.mem_req, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_mem_req_drop", bus.mem_req, 0);
        check("rr_busy_drop", bus.ld_busy, 0);
        check("rr_wr_en", bus.wr_en, 0);
        check("rr_ld_ready", bus.ld_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rr_post_req", bus.mem_req, 0);
        check("rr_post_busy", bus.ld_busy, 0);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
